mem_arbiter: RTL and testbench

- Shares one slow_memory port between the I-cache and D-cache miss/writeback interfaces so a single off-chip memory can serve the whole CHIP.
- Each cache side presents the slow_memory protocol unchanged: level read/write request held until a one-cycle ready pulse, with a 128-bit line and a [31:4] line address.
- Arbitration is fixed-priority (D over I) or round-robin. Commands are latched at grant. Per-port transaction counters are provided for cycle/perf reporting.

---
 rtl/mem_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (I/D cache) arbiter onto a single slow_memory port
//
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   i_read/i_write/i_addr/i_wdata  I-side request (held until i_ready)
//   i_rdata/i_ready                I-side read line / one-cycle completion
//   d_*                            same set for the D side
//   mem_read/mem_write/mem_addr/mem_wdata  latched command to slow_memory
//   mem_rdata/mem_ready            slow_memory response
//   busy                           a transaction is outstanding
//   cnt_i/cnt_d                    saturating completed-transaction counters
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int DATA_W = 128,
    parameter int RR_EN  = 0,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic              i_write,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_ready,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  cnt_i,
    output logic [CNT_W-1:0]  cnt_d
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;   // 1 = D side, 0 = I side
    logic               last_q, last_d;     // side granted most recently
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]  mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]   cnt_i_q, cnt_i_d;
    logic [CNT_W-1:0]   cnt_d_q, cnt_d_d;

    logic i_req, d_req, win_d;

    assign i_req = i_read | i_write;
    assign d_req = d_read | d_write;

    // Round-robin only matters on a tie: the side not granted last goes first.
    always_comb begin
        win_d = d_req;
        if (RR_EN != 0 && i_req && d_req) begin
            win_d = ~last_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cnt_i_d     = cnt_i_q;
        cnt_d_d     = cnt_d_q;
        i_ready     = 1'b0;
        d_ready     = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_req || d_req) begin
                    state_d     = BUSY;
                    owner_d     = win_d;
                    last_d      = win_d;
                    mem_read_d  = win_d ? d_read  : i_read;
                    mem_write_d = win_d ? d_write : i_write;
                    mem_addr_d  = win_d ? d_addr  : i_addr;
                    mem_wdata_d = win_d ? d_wdata : i_wdata;
                end
            end
            BUSY: begin
                // Requester inputs are not looked at here; the latched command holds.
                if (mem_ready) begin
                    i_ready     = ~owner_q;
                    d_ready     = owner_q;
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (owner_q) begin
                        if (cnt_d_q != '1) cnt_d_d = cnt_d_q + 1'b1;
                    end else begin
                        if (cnt_i_q != '1) cnt_i_d = cnt_i_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= 1'b0;
            last_q      <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cnt_i_q     <= '0;
            cnt_d_q     <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_i_q     <= cnt_i_d;
            cnt_d_q     <= cnt_d_d;
        end
    end

    assign mem_read  = mem_read_q;
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q == BUSY);
    assign cnt_i     = cnt_i_q;
    assign cnt_d     = cnt_d_q;
    // Read data is broadcast; only the ready pulse qualifies it.
    assign i_rdata   = mem_rdata;
    assign d_rdata   = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter (fixed-priority and round-robin builds)
module tb_mem_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         i_read[2], i_write[2], d_read[2], d_write[2], mem_ready[2];
    logic [27:0]  i_addr[2], d_addr[2], mem_addr[2];
    logic [127:0] i_wdata[2], d_wdata[2], mem_rdata[2], i_rdata[2], d_rdata[2], mem_wdata[2];
    logic         i_ready[2], d_ready[2], mem_read[2], mem_write[2], busy[2];
    logic [3:0]   cnt_i[2], cnt_d[2];

    int nvec = 0;
    int nerr = 0;
    int m_cnt_i[2], m_cnt_d[2];
    bit m_last[2];
    bit rr_of[2];

    mem_arbiter #(.ADDR_W(28), .DATA_W(128), .RR_EN(0), .CNT_W(4)) u0 (
        .clk(clk), .rst(rst),
        .i_read(i_read[0]), .i_write(i_write[0]), .i_addr(i_addr[0]), .i_wdata(i_wdata[0]),
        .i_rdata(i_rdata[0]), .i_ready(i_ready[0]),
        .d_read(d_read[0]), .d_write(d_write[0]), .d_addr(d_addr[0]), .d_wdata(d_wdata[0]),
        .d_rdata(d_rdata[0]), .d_ready(d_ready[0]),
        .mem_read(mem_read[0]), .mem_write(mem_write[0]), .mem_addr(mem_addr[0]),
        .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .mem_ready(mem_ready[0]),
        .busy(busy[0]), .cnt_i(cnt_i[0]), .cnt_d(cnt_d[0])
    );

    mem_arbiter #(.ADDR_W(28), .DATA_W(128), .RR_EN(1), .CNT_W(4)) u1 (
        .clk(clk), .rst(rst),
        .i_read(i_read[1]), .i_write(i_write[1]), .i_addr(i_addr[1]), .i_wdata(i_wdata[1]),
        .i_rdata(i_rdata[1]), .i_ready(i_ready[1]),
        .d_read(d_read[1]), .d_write(d_write[1]), .d_addr(d_addr[1]), .d_wdata(d_wdata[1]),
        .d_rdata(d_rdata[1]), .d_ready(d_ready[1]),
        .mem_read(mem_read[1]), .mem_write(mem_write[1]), .mem_addr(mem_addr[1]),
        .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .mem_ready(mem_ready[1]),
        .busy(busy[1]), .cnt_i(cnt_i[1]), .cnt_d(cnt_d[1])
    );

    task automatic check(input string tag, input int k, input logic [127:0] obs, input logic [127:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rand_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Arbitration rules: lone requester wins; tie -> D (fixed) or the side not granted last (RR).
    function automatic bit exp_winner(input bit rr, input bit last, input bit ir, input bit dr);
        if (!ir) return 1'b1;
        if (!dr) return 1'b0;
        if (!rr) return 1'b1;
        return ~last;
    endfunction

    task automatic clear_inputs(input int k);
        i_read[k] = 0; i_write[k] = 0; i_addr[k] = '0; i_wdata[k] = '0;
        d_read[k] = 0; d_write[k] = 0; d_addr[k] = '0; d_wdata[k] = '0;
        mem_ready[k] = 0; mem_rdata[k] = '0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cnt_i[k] = 0; m_cnt_d[k] = 0; m_last[k] = 1'b0;
        end
    endtask

    task automatic rand_req(input int k, input bit side);
        bit rd, wr;
        rd = 1'($urandom_range(0, 1));
        wr = !rd || ($urandom_range(0, 7) == 0);
        if (side) begin
            d_read[k] = rd; d_write[k] = wr; d_addr[k] = 28'($urandom); d_wdata[k] = rand_line();
        end else begin
            i_read[k] = rd; i_write[k] = wr; i_addr[k] = 28'($urandom); i_wdata[k] = rand_line();
        end
    endtask

    // One full transaction starting from IDLE with current requests presented.
    task automatic do_txn(input int k, input int lat, input bit perturb,
                          input logic [127:0] rdata, output bit win);
        bit ir, dr;
        logic er, ew;
        logic [27:0] ea;
        logic [127:0] ewd;
        ir = i_read[k] | i_write[k];
        dr = d_read[k] | d_write[k];
        win = 1'b0;
        if (!ir && !dr) return;
        win = exp_winner(rr_of[k], m_last[k], ir, dr);
        if (win) begin er = d_read[k]; ew = d_write[k]; ea = d_addr[k]; ewd = d_wdata[k]; end
        else     begin er = i_read[k]; ew = i_write[k]; ea = i_addr[k]; ewd = i_wdata[k]; end
        tick();
        m_last[k] = win;
        check("grant_mem_read", k, mem_read[k], er);
        check("grant_mem_write", k, mem_write[k], ew);
        check("grant_mem_addr", k, mem_addr[k], ea);
        check("grant_mem_wdata", k, mem_wdata[k], ewd);
        check("grant_busy", k, busy[k], 1'b1);
        check("early_ready", k, {i_ready[k], d_ready[k]}, 2'b00);
        for (int c = 0; c < lat; c++) begin
            if (perturb) begin
                if (win) begin d_addr[k] = 28'hFFFFFFF; i_read[k] = 1'b1; end
                else     begin i_addr[k] = 28'hFFFFFFF; d_read[k] = 1'b1; end
            end
            tick();
            check("hold_mem_addr", k, mem_addr[k], ea);
            check("hold_mem_read", k, mem_read[k], er);
            check("hold_busy", k, busy[k], 1'b1);
        end
        mem_ready[k] = 1'b1;
        mem_rdata[k] = rdata;
        #1;
        check("owner_ready", k, win ? d_ready[k] : i_ready[k], 1'b1);
        check("other_ready", k, win ? i_ready[k] : d_ready[k], 1'b0);
        check("owner_rdata", k, win ? d_rdata[k] : i_rdata[k], rdata);
        tick();
        mem_ready[k] = 1'b0;
        if (win) m_cnt_d[k] = (m_cnt_d[k] < 15) ? m_cnt_d[k] + 1 : 15;
        else     m_cnt_i[k] = (m_cnt_i[k] < 15) ? m_cnt_i[k] + 1 : 15;
        #1;
        check("done_busy", k, busy[k], 1'b0);
        check("done_mem_rw", k, {mem_read[k], mem_write[k]}, 2'b00);
        check("idle_ready", k, {i_ready[k], d_ready[k]}, 2'b00);
        check("cnt_i", k, cnt_i[k], m_cnt_i[k]);
        check("cnt_d", k, cnt_d[k], m_cnt_d[k]);
        if (win) begin d_read[k] = 0; d_write[k] = 0; end
        else     begin i_read[k] = 0; i_write[k] = 0; end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs(0);
        clear_inputs(1);
        model_reset();
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        bit w;
        bit exp_order[4];
        logic [127:0] a5;
        rr_of[0] = 1'b0;
        rr_of[1] = 1'b1;
        a5 = {16{8'hA5}};
        exp_order[0] = 1; exp_order[1] = 0; exp_order[2] = 1; exp_order[3] = 0;

        // Reset state
        do_reset();
        for (int k = 0; k < 2; k++) begin
            check("rst_mem_rw", k, {mem_read[k], mem_write[k]}, 2'b00);
            check("rst_mem_addr", k, mem_addr[k], 28'h0);
            check("rst_mem_wdata", k, mem_wdata[k], 128'h0);
            check("rst_busy", k, busy[k], 1'b0);
            check("rst_cnt", k, {cnt_i[k], cnt_d[k]}, 8'h00);
        end

        // Single D read, A5 line
        d_read[0] = 1'b1;
        d_addr[0] = 28'h0000010;
        do_txn(0, 0, 1'b0, a5, w);
        check("single_d_win", 0, w, 1'b1);

        // Fixed priority: simultaneous I read and D write
        i_read[0] = 1'b1; i_addr[0] = 28'h0000123;
        d_write[0] = 1'b1; d_addr[0] = 28'h0000456; d_wdata[0] = rand_line();
        do_txn(0, 2, 1'b0, rand_line(), w);
        check("prio_first_d", 0, w, 1'b1);
        do_txn(0, 1, 1'b0, rand_line(), w);
        check("prio_second_i", 0, w, 1'b0);
        check("prio_cnts", 0, {cnt_i[0], cnt_d[0]}, 8'h12);

        // Round-robin: both request continuously
        for (int t = 0; t < 4; t++) begin
            i_read[1] = 1'b1; i_addr[1] = 28'($urandom);
            d_read[1] = 1'b1; d_addr[1] = 28'($urandom);
            do_txn(1, t % 3, 1'b0, rand_line(), w);
            check("rr_order", 1, w, exp_order[t]);
        end
        check("rr_cnts", 1, {cnt_i[1], cnt_d[1]}, 8'h22);
        clear_inputs(1);

        // Mid-transaction changes are ignored
        d_read[0] = 1'b1; d_addr[0] = 28'h0000777;
        do_txn(0, 3, 1'b1, rand_line(), w);
        check("perturb_d_win", 0, w, 1'b1);
        do_txn(0, 0, 1'b0, rand_line(), w);
        check("perturb_then_i", 0, w, 1'b0);
        clear_inputs(0);

        // Asynchronous reset during a D read
        do_reset();
        d_read[0] = 1'b1; d_addr[0] = 28'h0000abc;
        tick();
        tick();
        tick();
        check("pre_rst_busy", 0, busy[0], 1'b1);
        rst = 1'b1;
        #1;
        check("async_rst_mem_read", 0, mem_read[0], 1'b0);
        check("async_rst_busy", 0, busy[0], 1'b0);
        d_read[0] = 1'b0;
        tick();
        rst = 1'b0;
        mem_ready[0] = 1'b1;
        #1;
        check("stray_ready_d", 0, d_ready[0], 1'b0);
        tick();
        mem_ready[0] = 1'b0;
        check("stray_cnt_d", 0, cnt_d[0], 4'h0);
        model_reset();

        // Counter saturation with 17 I reads
        for (int t = 0; t < 17; t++) begin
            i_read[0] = 1'b1; i_addr[0] = 28'($urandom);
            do_txn(0, t % 2, 1'b0, rand_line(), w);
        end
        check("sat_cnt_i", 0, cnt_i[0], 4'hF);

        // Randomized traffic against the model
        for (int k = 0; k < 2; k++) begin
            for (int t = 0; t < 40; t++) begin
                if (!(i_read[k] | i_write[k]) && $urandom_range(0, 1) == 1) rand_req(k, 1'b0);
                if (!(d_read[k] | d_write[k]) && $urandom_range(0, 1) == 1) rand_req(k, 1'b1);
                if (!(i_read[k] | i_write[k] | d_read[k] | d_write[k])) rand_req(k, 1'($urandom_range(0, 1)));
                do_txn(k, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), rand_line(), w);
            end
            clear_inputs(k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
